rename_map_table: RTL
=====================

RENAME_MAP_TABLE -- requirements
Module: rename_map_table

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ARCH_COUNT, 32, architectural registers
- PHYS_COUNT, 128, physical registers
- WRITE_PORTS, 4, rename write ports
- READ_PORTS, 8, lookup ports
- CKPT_COUNT, 4, snapshot slots, power of two, at least 2

REQ-002 Derived widths SHALL be AW=$clog2(ARCH_COUNT), PW=$clog2(PHYS_COUNT), CW=$clog2(CKPT_COUNT).

REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- sync_rst_n, in, 1, reset: asynchronous, active-low
- clk_en, in, 1, global state-update enable
- wr_en, in, WRITE_PORTS, per-port write strobe
- wr_arch_addr, in, WRITE_PORTS x AW, arch register to remap
- wr_phys_addr, in, WRITE_PORTS x PW, new physical mapping
- rd_arch_addr, in, READ_PORTS x AW, lookup address
- rd_phys_addr, out, READ_PORTS x PW, current mapping
- ckpt_req, in, 1, snapshot request
- ckpt_ack, out, 1, snapshot accepted this cycle
- ckpt_id, out, CW, slot ID granted when ckpt_ack=1
- ckpt_full, out, 1, all slots allocated
- ckpt_count, out, CW+1, allocated slot count
- ckpt_release, in, 1, free oldest slot (branch resolved correct)
- restore_en, in, 1, roll back to a snapshot
- restore_id, in, CW, snapshot to restore
- restore_err, out, 1, sticky illegal-restore flag

Function
REQ-004 Table reads SHALL be combinational: rd_phys_addr[j] = map[rd_arch_addr[j]], giving the state at the start of the cycle, with no bypass of same-cycle writes.

REQ-005 When clk_en=1, wr_en[i]=1 and restore_en=0, map[wr_arch_addr[i]] SHALL take wr_phys_addr[i] at the next clk edge.

REQ-006 When several enabled write ports target the same arch address, the highest port index SHALL win.

REQ-007 Snapshot slots SHALL be a circular FIFO with head (oldest), tail (next free) and count. Only head, tail and count are user-visible state.

REQ-008 ckpt_ack SHALL be combinational: ckpt_req && clk_en && !ckpt_full && !restore_en. ckpt_id SHALL equal tail.

REQ-009 On ckpt_ack, the slot at tail SHALL capture the start-of-cycle table, excluding same-cycle writes. Tail SHALL increment modulo CKPT_COUNT and count SHALL increment.

REQ-010 On ckpt_release with count>0 and clk_en=1, head SHALL increment and count SHALL decrement. A release with count=0 SHALL be ignored.

REQ-011 A restore is legal when restore_id lies within [head, tail) modulo CKPT_COUNT and count>0. On a legal restore with clk_en=1:
- the map SHALL be loaded from slot restore_id next cycle
- tail SHALL become restore_id
- count SHALL become the distance from head to restore_id, so the restored slot and all younger slots are freed

REQ-012 Restore SHALL take priority over writes and snapshot requests in the same cycle; both SHALL be dropped.

REQ-013 A simultaneous legal restore and release SHALL apply both. If the release frees the slot being restored, the restore SHALL still load the table, and count SHALL become 0 with head=tail=restore_id+1.

REQ-014 An illegal restore SHALL leave all state unchanged and set restore_err, which stays set until reset.

REQ-015 A simultaneous ckpt_ack and release SHALL leave count unchanged and advance both pointers.

REQ-016 ckpt_full SHALL equal (count==CKPT_COUNT) and be driven from registered state only.

REQ-017 With clk_en=0, no state SHALL change and ckpt_ack SHALL be 0.

Reset
REQ-018 Asserting sync_rst_n low SHALL immediately set map[a]=a for every a, clear head, tail, count and restore_err, and force ckpt_full=0 and ckpt_count=0.

REQ-019 Reset asserted mid-operation SHALL discard every snapshot. Slot contents need not be cleared.

Structure
REQ-020 A shared package (rename_pkg) SHALL hold the default parameter constants and a packed map-vector typedef.

REQ-021 Snapshot storage SHALL be one sub-module, map_ckpt_store: CKPT_COUNT x ARCH_COUNT x PW storage, one write port, one full-table read port, no reset.

Verification
REQ-022 After reset, reading arch 0..31 SHALL return phys 0..31; ckpt_count=0 and ckpt_full=0.

REQ-023 Ports 0 and 3 both write arch 5 (phys 40 and phys 77) -> next cycle arch 5 reads 77; the same-cycle read returned 5.

REQ-024 Snapshot 4 times -> IDs 0,1,2,3 and ckpt_full=1; a fifth request gives ckpt_ack=0; a release then allows ID 0 to be granted again (wrap).

REQ-025 Map arch 7 to 90, snapshot (ID 0), map arch 7 to 100, snapshot (ID 1), restore ID 0 -> arch 7 reads 90 and ckpt_count=0. A restore, write and ckpt_req in the same cycle -> write dropped and no ack.

REQ-026 Restore an unallocated ID -> restore_err=1 and table unchanged. A further snapshot then succeeds, and restore_err stays 1 until reset.

Source files
------------

// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rename_pkg
//  Description : Shared defaults and the packed map-vector type used by the
//                register-rename map table and its snapshot store.
//  Revision    : 1.0 - initial release
// ============================================================================
package rename_pkg;

    localparam int c_arch_count  = 32;
    localparam int c_phys_count  = 128;
    localparam int c_write_ports = 4;
    localparam int c_read_ports  = 8;
    localparam int c_ckpt_count  = 4;

    localparam int c_aw = $clog2(c_arch_count);
    localparam int c_pw = $clog2(c_phys_count);
    localparam int c_cw = $clog2(c_ckpt_count);

    // Whole arch->phys table at default sizing, one PW-wide entry per arch reg
    typedef logic [c_arch_count-1:0][c_pw-1:0] map_vec_t;

endpackage
`default_nettype wire

// File: rtl/map_ckpt_store.sv
`default_nettype none
// ============================================================================
//  Module      : map_ckpt_store
//  Description : Snapshot storage for the rename map. One write port that
//                captures a full table, one full-table combinational read.
//                Contents are not reset; validity is tracked by the owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module map_ckpt_store
    import rename_pkg::*;
#(
    parameter int CKPT_COUNT = c_ckpt_count,
    parameter int ARCH_COUNT = c_arch_count,
    parameter int PW         = c_pw,
    localparam int CW        = $clog2(CKPT_COUNT)
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [CW-1:0]              wr_id,
    input  logic [ARCH_COUNT*PW-1:0]   wr_data,
    input  logic [CW-1:0]              rd_id,
    output logic [ARCH_COUNT*PW-1:0]   rd_data
);

    logic [ARCH_COUNT*PW-1:0] r_mem [CKPT_COUNT];

    // Capture one full table into the addressed slot
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_id] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_id];

endmodule
`default_nettype wire

// File: rtl/rename_map_table.sv
`default_nettype none
// ============================================================================
//  Module      : rename_map_table
//  Description : Architectural-to-physical register map with multi-port
//                writes, combinational lookups and a circular FIFO of
//                table snapshots for branch rollback.
//  Revision    : 1.0 - initial release
// ============================================================================
module rename_map_table
    import rename_pkg::*;
#(
    parameter int ARCH_COUNT  = c_arch_count,
    parameter int PHYS_COUNT  = c_phys_count,
    parameter int WRITE_PORTS = c_write_ports,
    parameter int READ_PORTS  = c_read_ports,
    parameter int CKPT_COUNT  = c_ckpt_count,
    localparam int AW         = $clog2(ARCH_COUNT),
    localparam int PW         = $clog2(PHYS_COUNT),
    localparam int CW         = $clog2(CKPT_COUNT)
) (
    input  logic                                clk,
    input  logic                                sync_rst_n,
    input  logic                                clk_en,
    input  logic [WRITE_PORTS-1:0]              wr_en,
    input  logic [WRITE_PORTS-1:0][AW-1:0]      wr_arch_addr,
    input  logic [WRITE_PORTS-1:0][PW-1:0]      wr_phys_addr,
    input  logic [READ_PORTS-1:0][AW-1:0]       rd_arch_addr,
    output logic [READ_PORTS-1:0][PW-1:0]       rd_phys_addr,
    input  logic                                ckpt_req,
    output logic                                ckpt_ack,
    output logic [CW-1:0]                       ckpt_id,
    output logic                                ckpt_full,
    output logic [CW:0]                         ckpt_count,
    input  logic                                ckpt_release,
    input  logic                                restore_en,
    input  logic [CW-1:0]                       restore_id,
    output logic                                restore_err
);

    logic [ARCH_COUNT-1:0][PW-1:0] r_map;
    logic [ARCH_COUNT-1:0][PW-1:0] w_map_nxt;
    logic [ARCH_COUNT-1:0][PW-1:0] w_ckpt_rd;
    logic [CW-1:0]                 r_head;
    logic [CW-1:0]                 r_tail;
    logic [CW:0]                   r_count;
    logic                          r_restore_err;
    logic [CW-1:0]                 w_head_nxt;
    logic [CW-1:0]                 w_tail_nxt;
    logic [CW:0]                   w_count_nxt;
    logic [CW-1:0]                 w_offset;
    logic                          w_full;
    logic                          w_legal;
    logic                          w_restore_ok;
    logic                          w_restore_bad;
    logic                          w_release;

    // Slot age relative to the oldest live snapshot; live slots are those
    // with an age below the current count (covers the full/wrapped case).
    assign w_offset      = restore_id - r_head;
    assign w_full        = (r_count == (CW+1)'(CKPT_COUNT));
    assign w_legal       = (r_count != '0) && ({1'b0, w_offset} < r_count);
    assign w_restore_ok  = clk_en && restore_en && w_legal;
    assign w_restore_bad = clk_en && restore_en && !w_legal;
    // An illegal restore freezes everything, including a paired release
    assign w_release     = clk_en && ckpt_release && (r_count != '0) && !w_restore_bad;

    assign ckpt_ack    = ckpt_req && clk_en && !w_full && !restore_en;
    assign ckpt_id     = r_tail;
    assign ckpt_full   = w_full;
    assign ckpt_count  = r_count;
    assign restore_err = r_restore_err;

    generate
        for (genvar j = 0; j < READ_PORTS; j++) begin : g_rd
            assign rd_phys_addr[j] = r_map[rd_arch_addr[j]];
        end
    endgenerate

    map_ckpt_store #(
        .CKPT_COUNT (CKPT_COUNT),
        .ARCH_COUNT (ARCH_COUNT),
        .PW         (PW)
    ) u_store (
        .clk     (clk),
        .wr_en   (ckpt_ack),
        .wr_id   (r_tail),
        .wr_data (r_map),
        .rd_id   (restore_id),
        .rd_data (w_ckpt_rd)
    );

    // Next table and FIFO pointers: restore wins over writes and snapshots
    always_comb begin
        w_map_nxt   = r_map;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (w_restore_ok) begin
            w_map_nxt = w_ckpt_rd;
            if (w_release) begin
                w_head_nxt = r_head + 1'b1;
                if (w_offset == '0) begin
                    // Release frees the restored slot itself: FIFO empties
                    w_tail_nxt  = restore_id + 1'b1;
                    w_count_nxt = '0;
                end else begin
                    w_tail_nxt  = restore_id;
                    w_count_nxt = {1'b0, w_offset} - 1'b1;
                end
            end else begin
                w_tail_nxt  = restore_id;
                w_count_nxt = {1'b0, w_offset};
            end
        end else if (clk_en && !restore_en) begin
            // Ascending order so the highest-index port wins on a collision
            for (int i = 0; i < WRITE_PORTS; i++) begin
                if (wr_en[i]) begin
                    w_map_nxt[wr_arch_addr[i]] = wr_phys_addr[i];
                end
            end
            if (ckpt_ack) begin
                w_tail_nxt = r_tail + 1'b1;
            end
            if (w_release) begin
                w_head_nxt = r_head + 1'b1;
            end
            w_count_nxt = r_count + (CW+1)'(ckpt_ack) - (CW+1)'(w_release);
        end
    end

    // State register; reset restores the identity mapping and empties the FIFO
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            for (int a = 0; a < ARCH_COUNT; a++) begin
                r_map[a] <= PW'(a);
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_restore_err <= 1'b0;
        end else begin
            r_map   <= w_map_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            if (w_restore_bad) begin
                r_restore_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
